// File: rtl/jstk_spi_reader.sv
// SPI master that polls a joystick module: sends a 5-byte command frame
// (LED bits in byte 1) and assembles X/Y position and button states.
module jstk_spi_reader #(
  parameter int CLK_DIV     = 50,
  parameter int SS_SETUP    = 1500,
  parameter int BYTE_GAP    = 1000,
  parameter int POLL_PERIOD = 1_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       miso,
  input  logic [1:0] led,
  output logic       ss,
  output logic       sclk,
  output logic       mosi,
  output logic [9:0] x_val,
  output logic [9:0] y_val,
  output logic [2:0] buttons,
  output logic       valid
);

  localparam int BIT_LEN = 2 * CLK_DIV;
  localparam int CNT_MAX = (SS_SETUP > BYTE_GAP) ?
                           ((SS_SETUP > BIT_LEN) ? SS_SETUP : BIT_LEN) :
                           ((BYTE_GAP > BIT_LEN) ? BYTE_GAP : BIT_LEN);
  localparam int CW = $clog2(CNT_MAX + 1);
  localparam int PW = $clog2(POLL_PERIOD + 1);

  localparam logic [CW-1:0] SETUP_LAST = CW'(SS_SETUP - 1);
  localparam logic [CW-1:0] GAP_LAST   = CW'(BYTE_GAP - 1);
  localparam logic [CW-1:0] BIT_LAST   = CW'(BIT_LEN - 1);
  localparam logic [CW-1:0] HI_START   = CW'(CLK_DIV);
  localparam logic [PW-1:0] POLL_LAST  = PW'(POLL_PERIOD - 1);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_SHIFT, S_GAP, S_DONE} state_t;

  state_t        state_q, state_d;
  logic          ss_q, ss_d, sclk_q, sclk_d, mosi_q, mosi_d, valid_q, valid_d;
  logic          start_q, start_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [PW-1:0] poll_q, poll_d;
  logic [2:0]    bit_q, bit_d, byte_q, byte_d;
  logic [1:0]    led_q, led_d;
  logic [7:0]    rx_q, rx_d;
  logic [9:0]    xs_q, xs_d, ys_q, ys_d, x_q, x_d, y_q, y_d;
  logic [2:0]    btn_q, btn_d;
  logic          poll_hit;

  function automatic logic tx_bit(input logic [2:0] b, input logic [2:0] i,
                                  input logic [1:0] l);
    logic [7:0] t;
    t = (b == 3'd0) ? {6'b100000, l} : 8'h00;
    return t[3'd7 - i];
  endfunction

  assign cnt_inc  = cnt_q + 1'b1;
  assign poll_hit = (poll_q == POLL_LAST);

  always_comb begin
    state_d = state_q;
    ss_d    = ss_q;
    sclk_d  = sclk_q;
    mosi_d  = mosi_q;
    valid_d = 1'b0;
    start_d = start_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    led_d   = led_q;
    rx_d    = rx_q;
    xs_d    = xs_q;
    ys_d    = ys_q;
    x_d     = x_q;
    y_d     = y_q;
    btn_d   = btn_q;
    // Poll counter saturates so a late transaction restarts right after DONE.
    poll_d  = poll_hit ? poll_q : poll_q + 1'b1;

    case (state_q)
      S_IDLE: begin
        ss_d   = 1'b1;
        sclk_d = 1'b0;
        mosi_d = 1'b0;
        if (start_q || poll_hit) state_d = S_SETUP;
      end
      S_SETUP: begin
        if (cnt_q == SETUP_LAST) begin
          state_d = S_SHIFT;
          cnt_d   = '0;
          bit_d   = 3'd0;
          byte_d  = 3'd0;
          mosi_d  = tx_bit(3'd0, 3'd0, led_q);
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_SHIFT: begin
        if (cnt_q != BIT_LAST) begin
          cnt_d  = cnt_inc;
          sclk_d = (cnt_inc >= HI_START);
          if (cnt_inc == HI_START) rx_d = {rx_q[6:0], miso};
        end else begin
          cnt_d  = '0;
          sclk_d = 1'b0;
          if (bit_q != 3'd7) begin
            bit_d  = bit_q + 3'd1;
            mosi_d = tx_bit(byte_q, bit_q + 3'd1, led_q);
          end else begin
            bit_d  = 3'd0;
            mosi_d = 1'b0;
            // Bytes land in staging regs; outputs move together in DONE.
            case (byte_q)
              3'd0:    xs_d[7:0] = rx_q;
              3'd1:    xs_d[9:8] = rx_q[1:0];
              3'd2:    ys_d[7:0] = rx_q;
              3'd3:    ys_d[9:8] = rx_q[1:0];
              default: begin
                x_d   = xs_q;
                y_d   = ys_q;
                btn_d = rx_q[2:0];
              end
            endcase
            if (byte_q == 3'd4) begin
              state_d = S_DONE;
              ss_d    = 1'b1;
              valid_d = 1'b1;
            end else begin
              state_d = S_GAP;
              byte_d  = byte_q + 3'd1;
            end
          end
        end
      end
      S_GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = S_SHIFT;
          cnt_d   = '0;
          mosi_d  = tx_bit(byte_q, 3'd0, led_q);
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_DONE:  state_d = poll_hit ? S_SETUP : S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (state_d == S_SETUP && state_q != S_SETUP) begin
      ss_d    = 1'b0;
      sclk_d  = 1'b0;
      mosi_d  = 1'b0;
      cnt_d   = '0;
      poll_d  = '0;
      start_d = 1'b0;
      led_d   = led;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      ss_q    <= 1'b1;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      valid_q <= 1'b0;
      start_q <= 1'b1;
      cnt_q   <= '0;
      poll_q  <= '0;
      bit_q   <= 3'd0;
      byte_q  <= 3'd0;
      led_q   <= 2'd0;
      rx_q    <= 8'd0;
      xs_q    <= 10'd0;
      ys_q    <= 10'd0;
      x_q     <= 10'd512;
      y_q     <= 10'd512;
      btn_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      ss_q    <= ss_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      valid_q <= valid_d;
      start_q <= start_d;
      cnt_q   <= cnt_d;
      poll_q  <= poll_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      led_q   <= led_d;
      rx_q    <= rx_d;
      xs_q    <= xs_d;
      ys_q    <= ys_d;
      x_q     <= x_d;
      y_q     <= y_d;
      btn_q   <= btn_d;
    end
  end

  assign ss      = ss_q;
  assign sclk    = sclk_q;
  assign mosi    = mosi_q;
  assign valid   = valid_q;
  assign x_val   = x_q;
  assign y_val   = y_q;
  assign buttons = btn_q;

endmodule

// File: tb/tb_jstk_spi_reader.sv
// Bench for jstk_spi_reader: a joystick slave model answers each frame and
// records the command bytes; results are compared against arithmetic expectations.
module tb_jstk_spi_reader;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       miso = 1'b0;
  logic [1:0] led = 2'b00;
  logic       ss, sclk, mosi, valid;
  logic [9:0] x_val, y_val;
  logic [2:0] buttons;

  always #5 clk = ~clk;

  jstk_spi_reader #(
    .CLK_DIV(2), .SS_SETUP(4), .BYTE_GAP(3), .POLL_PERIOD(200)
  ) dut (
    .clk(clk), .rst(rst), .miso(miso), .led(led),
    .ss(ss), .sclk(sclk), .mosi(mosi),
    .x_val(x_val), .y_val(y_val), .buttons(buttons), .valid(valid)
  );

  int checks = 0;
  int failures = 0;

  // Slave-side observations.
  int         cyc = 0, bitcnt = 0, valid_cnt = 0;
  int         ss_fall_cyc = 0, valid_cyc = 0, done_edges = 0;
  logic [7:0] rsp [5];
  logic [7:0] cur [5];
  logic [7:0] mosi_b [5];
  logic [7:0] done_mosi [5];
  logic       prev_ss = 1'b1, prev_sclk = 1'b0;
  int         last_x = 512;

  initial begin
    forever begin
      @(posedge clk); #1;
      cyc++;
      if (!rst && prev_ss && !ss) begin
        ss_fall_cyc = cyc;
        bitcnt = 0;
        cur = rsp;
        for (int i = 0; i < 5; i++) mosi_b[i] = 8'h00;
        miso = cur[0][7];
      end
      if (!ss && sclk && !prev_sclk) begin
        if (bitcnt < 40) mosi_b[bitcnt/8] = {mosi_b[bitcnt/8][6:0], mosi};
        bitcnt++;
        if (bitcnt < 40) miso = cur[bitcnt/8][7 - (bitcnt % 8)];
      end
      if (valid === 1'b1) begin
        valid_cnt++;
        valid_cyc = cyc;
        done_edges = bitcnt;
        done_mosi = mosi_b;
      end
      prev_ss = ss;
      prev_sclk = sclk;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max && !ok; i++) begin
      @(posedge clk); #2;
      if (valid === 1'b1) ok = 1'b1;
    end
    check("valid_seen", {31'd0, ok}, 32'd1);
  endtask

  task automatic wait_ss_low(input int max);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < max && !ok; i++) begin
      @(posedge clk); #2;
      if (ss === 1'b0) ok = 1'b1;
    end
    check("ss_low_seen", {31'd0, ok}, 32'd1);
  endtask

  // Called in the valid cycle; rsp still holds the frame the slave answered with.
  task automatic check_done(input string tag, input logic [1:0] l);
    int ex, ey, eb;
    ex = (int'(rsp[1]) % 4) * 256 + int'(rsp[0]);
    ey = (int'(rsp[3]) % 4) * 256 + int'(rsp[2]);
    eb = int'(rsp[4]) % 8;
    check({tag, "_x"}, x_val, ex);
    check({tag, "_y"}, y_val, ey);
    check({tag, "_btn"}, buttons, eb);
    check({tag, "_byte1"}, done_mosi[0], 32'h80 + l);
    check({tag, "_bytes2to5"}, {done_mosi[1], done_mosi[2], done_mosi[3], done_mosi[4]}, 0);
    check({tag, "_edges"}, done_edges, 40);
    check({tag, "_latency"}, valid_cyc - ss_fall_cyc, 176);
    @(posedge clk); #2;
    check({tag, "_pulse"}, valid, 0);
    check({tag, "_ss_idle"}, ss, 1);
    check({tag, "_x_hold"}, x_val, ex);
    last_x = ex;
  endtask

  initial begin
    bit         ok;
    int         prev_v, vc;
    logic [1:0] lk;

    rsp = '{8'h34, 8'h02, 8'hCD, 8'h01, 8'h05};
    led = 2'b11;
    repeat (3) @(posedge clk);
    #2;
    check("rst_ss", ss, 1);
    check("rst_sclk", sclk, 0);
    check("rst_mosi", mosi, 0);
    check("rst_x", x_val, 512);
    check("rst_y", y_val, 512);
    check("rst_btn", buttons, 0);
    check("rst_valid", valid, 0);

    @(negedge clk) rst = 1'b0;
    @(posedge clk); #2;
    check("first_setup_ss", ss, 0);
    wait_valid(400, ok);
    check("fixed_x564", x_val, 564);
    check("fixed_y461", y_val, 461);
    check("fixed_btn", buttons, 3'b101);
    check_done("fixed", 2'b11);
    prev_v = valid_cyc;

    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 5; i++) rsp[i] = 8'($urandom_range(0, 255));
      lk = 2'($urandom_range(0, 3));
      led = lk;
      wait_valid(300, ok);
      check("period", valid_cyc - prev_v, 200);
      prev_v = valid_cyc;
      check_done("rnd", lk);
    end

    rsp = '{8'hFF, 8'hFF, 8'h00, 8'hFC, 8'hF8};
    led = 2'b00;
    wait_valid(300, ok);
    check("mask_x", x_val, 1023);
    check("mask_y", y_val, 0);
    check("mask_btn", buttons, 0);
    check_done("mask", 2'b00);

    for (int i = 0; i < 5; i++) rsp[i] = 8'($urandom_range(0, 255));
    wait_ss_low(300);
    repeat (10) @(posedge clk);
    led = 2'b01;
    wait_valid(300, ok);
    check_done("led_mid", 2'b00);
    for (int i = 0; i < 5; i++) rsp[i] = 8'($urandom_range(0, 255));
    wait_valid(300, ok);
    check_done("led_next", 2'b01);

    for (int i = 0; i < 5; i++) rsp[i] = 8'($urandom_range(0, 255));
    wait_ss_low(300);
    repeat (80) @(posedge clk);
    #2;
    check("hold_x_mid", x_val, last_x);
    check("in_byte3", bitcnt / 8, 2);
    vc = valid_cnt;
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #2;
    check("abort_ss", ss, 1);
    check("abort_sclk", sclk, 0);
    check("abort_x", x_val, 512);
    check("abort_y", y_val, 512);
    check("abort_btn", buttons, 0);
    check("abort_valid", valid, 0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #2;
    check("restart_ss", ss, 0);
    check("no_valid_abort", valid_cnt - vc, 0);
    wait_valid(300, ok);
    check("one_valid_after", valid_cnt - vc, 1);
    check_done("after_rst", 2'b01);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/jstk_spi_reader.md
JSTK_SPI_READER -- requirements
Module: jstk_spi_reader

Interface
REQ-001 Parameter CLK_DIV, default 50, is the SCLK half-period in clk cycles (1 MHz SCLK at 100 MHz).
REQ-002 Parameter SS_SETUP, default 1500, is the number of clk cycles from SS falling to the first SCLK low phase (15 us).
REQ-003 Parameter BYTE_GAP, default 1000, is the number of clk cycles of SCLK-low idle between bytes (10 us).
REQ-004 Parameter POLL_PERIOD, default 1_000_000, is the number of clk cycles between transaction starts (10 ms).
REQ-005 clk  input  1  system clock, 100 MHz; single clock domain.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 miso  input  1  joystick serial data; sampled only as described in REQ-016.
REQ-008 led  input  2  LED command bits sent in byte 1.
REQ-009 ss  output  1  slave select, active-low.
REQ-010 sclk  output  1  SPI clock, mode 0, idle low.
REQ-011 mosi  output  1  SPI command data, MSB first.
REQ-012 x_val  output  10  latest X position.
REQ-013 y_val  output  10  latest Y position; feeds the Y steering stage directly.
REQ-014 buttons  output  3  latest button states.
REQ-015 valid  output  1  one-cycle pulse when x_val, y_val and buttons update.

Function
REQ-016 Bit timing: each bit has an SCLK-low phase of CLK_DIV cycles followed by an SCLK-high phase of CLK_DIV cycles. mosi is valid from the first cycle of the low phase. miso is registered on the cycle sclk transitions 0->1. Bits are MSB first.
REQ-017 FSM states: IDLE, SETUP, SHIFT, GAP, DONE. All outputs are registered.
REQ-018 IDLE: ss=1, sclk=0, mosi=0. Go to SETUP when the poll counter reaches POLL_PERIOD-1 since the previous start, or on the first cycle after rst deasserts.
REQ-019 SETUP: ss=0, sclk=0. led is latched on SETUP entry. Go to SHIFT after SS_SETUP cycles.
REQ-020 SHIFT: shifts 8 bits per REQ-016. After the 8th high phase, sclk=0. Go to GAP after bytes 1-4 and to DONE after byte 5.
REQ-021 GAP: ss=0, sclk=0 for BYTE_GAP cycles, then return to SHIFT for the next byte.
REQ-022 MOSI content: byte 1 = {6'b100000, led_latched}; bytes 2-5 = 8'h00.
REQ-023 Assembly: x_val = {byte2[1:0], byte1}, y_val = {byte4[1:0], byte3}, buttons = byte5[2:0]. Unused upper bits of bytes 2, 4 and 5 are ignored.
REQ-024 DONE lasts exactly 1 cycle: ss=1, x_val/y_val/buttons updated, valid=1. Then go to IDLE.
REQ-025 Outputs hold their values between DONE cycles. No partial update is ever visible.
REQ-026 The poll counter runs free from each SETUP entry. If a transaction outlasts POLL_PERIOD, the next SETUP begins on the cycle after DONE.
REQ-027 Changes on led during a transaction have no effect until the next SETUP entry.
REQ-028 The ss, sclk and mosi outputs are glitch-free: each changes at most once per clk cycle, straight from flops.

Reset
REQ-029 While rst=1, on every clk edge: state=IDLE, ss=1, sclk=0, mosi=0, x_val=10'd512, y_val=10'd512, buttons=0, valid=0, and all counters are cleared.
REQ-030 If rst is asserted mid-transaction, the transaction is abandoned. ss=1 on the next edge, outputs take reset values, and no valid pulse is produced.
REQ-031 The first transaction starts with SETUP on the first cycle after rst deasserts.

Verification
REQ-032 Bench parameters are CLK_DIV=2, SS_SETUP=4, BYTE_GAP=3, POLL_PERIOD=200. A transaction is therefore 4+160+12 cycles plus DONE.
REQ-033 Scenario: the slave model returns 0x34,0x02,0xCD,0x01,0x05 -> x_val=564, y_val=461, buttons=3'b101, and valid is high for exactly 1 cycle.
REQ-034 Scenario: led=2'b11 -> mosi bits in byte 1 = 8'h83, and bytes 2-5 are all 0. A check counts exactly 40 sclk rising edges while ss=0.
REQ-035 Scenario: continuous run -> consecutive valid pulses are exactly 200 cycles apart, and SETUP starts on the first cycle after rst release.
REQ-036 Scenario: rst pulsed during byte 3 -> ss=1 next cycle, x_val=y_val=512, no valid pulse. A fresh transaction starts after release.
REQ-037 Scenario: led changed from 2'b00 to 2'b01 mid-transaction -> the current byte 1 was 8'h80, and the next transaction's byte 1 is 8'h81.
REQ-038 Scenario: slave returns 0xFF,0xFF,0x00,0xFC,0xF8 -> x_val=1023, y_val=0, buttons=0, showing that upper bits are masked.
